// File: rtl/knn_distance_streamer.sv
// Producer side of the kNN sorter: reads N samples, streams (index, squared distance)
// pairs through a fixed 3-stage pipeline, clears the sorter first and flags done at the end.
module knn_distance_streamer #(
    parameter int featureWidth = 8,
    parameter int numFeatures  = 4,
    parameter int addrWidth    = 7,
    parameter int dataWidth    = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [31:0]                         numSamples,
    input  logic [numFeatures*featureWidth-1:0] query,
    output logic                                memRdEn,
    output logic [addrWidth-1:0]                memAddr,
    input  logic [numFeatures*featureWidth-1:0] memData,
    output logic                                sorterClear,
    output logic                                valid,
    output logic [31:0]                         dataName,
    output logic [dataWidth-1:0]                dataValue,
    output logic                                done,
    output logic                                busy,
    output logic [2:0]                          dbgState
);

    localparam int FW   = featureWidth;
    localparam int SW   = numFeatures * featureWidth;
    localparam int MAXS = 1 << addrWidth;
    localparam int SQW  = 2 * featureWidth;
    localparam int SUMW = SQW + $clog2(numFeatures);
    localparam int WW   = ((SUMW > dataWidth) ? SUMW : dataWidth) + 1;
    // Largest legal distance; all-ones is reserved as the sorter's empty marker.
    localparam logic [WW-1:0] SAT_MAX = {{(WW-dataWidth){1'b0}}, {dataWidth{1'b1}}} - WW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_armed;
    logic [SW-1:0]        r_query;
    logic [addrWidth:0]   r_cnt;
    logic [addrWidth-1:0] r_last;
    logic [addrWidth-1:0] r_addr;
    logic                 r_rd;
    logic                 r_clear;
    logic                 r_done;
    logic                 r_busy;

    logic                 r_p0_v;
    logic [addrWidth-1:0] r_p0_name;
    logic                 r_p1_v;
    logic [addrWidth-1:0] r_p1_name;
    logic [SQW-1:0]       r_sq [numFeatures];
    logic                 r_valid;
    logic [addrWidth-1:0] r_name;
    logic [dataWidth-1:0] r_value;

    logic [addrWidth:0]   w_cnt;
    logic [FW-1:0]        w_diff [numFeatures];
    logic [SQW-1:0]       w_sq [numFeatures];
    logic [WW-1:0]        w_sum;
    logic [dataWidth-1:0] w_value;

    assign w_cnt = (numSamples >= 32'(MAXS)) ? (addrWidth+1)'(MAXS) : numSamples[addrWidth:0];

    always_comb begin
        for (int f = 0; f < numFeatures; f++) begin
            w_diff[f] = (r_query[f*FW +: FW] > memData[f*FW +: FW])
                      ? r_query[f*FW +: FW] - memData[f*FW +: FW]
                      : memData[f*FW +: FW] - r_query[f*FW +: FW];
            w_sq[f]   = SQW'(w_diff[f]) * SQW'(w_diff[f]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int f = 0; f < numFeatures; f++) begin
            w_sum = w_sum + WW'(r_sq[f]);
        end
        w_value = (w_sum > SAT_MAX) ? SAT_MAX[dataWidth-1:0] : w_sum[dataWidth-1:0];
    end

    // r_armed masks a start sampled on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_query <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_clear <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_clear <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && r_armed) begin
                        r_query <= query;
                        r_cnt   <= w_cnt;
                        r_last  <= w_cnt[addrWidth-1:0] - addrWidth'(1);
                        r_clear <= 1'b1;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt != '0) begin
                        r_rd    <= 1'b1;
                        r_addr  <= '0;
                        r_state <= S_STREAM;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_STREAM: begin
                    if (r_addr == r_last) begin
                        r_rd    <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + addrWidth'(1);
                    end
                end
                S_DRAIN: begin
                    // Both internal stages empty means the last pair is on the outputs now.
                    if (!r_p0_v && !r_p1_v) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p0_v    <= 1'b0;
            r_p0_name <= '0;
            r_p1_v    <= 1'b0;
            r_p1_name <= '0;
            for (int f = 0; f < numFeatures; f++) begin
                r_sq[f] <= '0;
            end
            r_valid   <= 1'b0;
            r_name    <= '0;
            r_value   <= '0;
        end else begin
            r_p0_v    <= r_rd;
            r_p0_name <= r_addr;
            r_p1_v    <= r_p0_v;
            r_p1_name <= r_p0_name;
            for (int f = 0; f < numFeatures; f++) begin
                r_sq[f] <= w_sq[f];
            end
            r_valid   <= r_p1_v;
            r_name    <= r_p1_name;
            r_value   <= w_value;
        end
    end

    assign memRdEn     = r_rd;
    assign memAddr     = r_addr;
    assign sorterClear = r_clear;
    assign valid       = r_valid;
    assign dataName    = 32'(r_name);
    assign dataValue   = r_value;
    assign done        = r_done;
    assign busy        = r_busy;
    assign dbgState    = r_state;

endmodule

// File: tb/tb_knn_distance_streamer.sv
// Directed bench for knn_distance_streamer: main instance (32-bit distances) plus a
// 16-bit-distance instance for saturation.
module tb_knn_distance_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] numSamples = '0;
    logic [31:0] query = '0;
    logic        memRdEn;
    logic [6:0]  memAddr;
    logic [31:0] memData = '0;
    logic        sorterClear, valid, done, busy;
    logic [31:0] dataName, dataValue;
    logic [2:0]  dbgState;

    logic        s_start = 1'b0;
    logic [31:0] s_numSamples = '0;
    logic [31:0] s_query = '0;
    logic        s_memRdEn;
    logic [6:0]  s_memAddr;
    logic [31:0] s_memData = '0;
    logic        s_sorterClear, s_valid, s_done, s_busy;
    logic [31:0] s_dataName;
    logic [15:0] s_dataValue;
    logic [2:0]  s_dbgState;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:127];

    always #5 clk = ~clk;

    knn_distance_streamer #(.featureWidth(8), .numFeatures(4), .addrWidth(7), .dataWidth(32)) dut (
        .clk(clk), .reset(reset), .start(start), .numSamples(numSamples), .query(query),
        .memRdEn(memRdEn), .memAddr(memAddr), .memData(memData), .sorterClear(sorterClear),
        .valid(valid), .dataName(dataName), .dataValue(dataValue), .done(done), .busy(busy),
        .dbgState(dbgState)
    );

    knn_distance_streamer #(.featureWidth(8), .numFeatures(4), .addrWidth(7), .dataWidth(16)) dut_sat (
        .clk(clk), .reset(reset), .start(s_start), .numSamples(s_numSamples), .query(s_query),
        .memRdEn(s_memRdEn), .memAddr(s_memAddr), .memData(s_memData), .sorterClear(s_sorterClear),
        .valid(s_valid), .dataName(s_dataName), .dataValue(s_dataValue), .done(s_done), .busy(s_busy),
        .dbgState(s_dbgState)
    );

    // Synchronous sample memories: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (memRdEn) memData <= mem[memAddr];
        if (s_memRdEn) s_memData <= 32'hFFFF_FFFF;
    end

    // Monitor: records every streamed pair and strobe with its cycle stamp.
    int          cyc = 0;
    int          rd_cnt = 0;
    int          overlap = 0;
    logic [31:0] got_name_q [$];
    logic [31:0] got_val_q [$];
    int          got_cyc_q [$];
    int          clr_cyc_q [$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid) begin
            got_name_q.push_back(dataName);
            got_val_q.push_back(dataValue);
            got_cyc_q.push_back(cyc);
        end
        if (sorterClear) clr_cyc_q.push_back(cyc);
        if (memRdEn) rd_cnt = rd_cnt + 1;
        if (valid && done) overlap = overlap + 1;
    end

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic start_query(input logic [31:0] n, input logic [31:0] q);
        @(negedge clk);
        start = 1'b1;
        numSamples = n;
        query = q;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_basic_mem();
        mem[0] = pk(8'd13, 8'd10, 8'd10, 8'd6);
        mem[1] = pk(8'd10, 8'd10, 8'd10, 8'd10);
        mem[2] = pk(8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({memRdEn, sorterClear, valid, done, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 00000", {memRdEn, sorterClear, valid, done, busy});
        end
        checks++;
        if (memAddr !== 7'd0 || dataName !== 32'd0 || dataValue !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: got addr=%0d name=%0d value=%0d expected 0", memAddr, dataName, dataValue);
        end
        // Start coincident with reset release must be ignored.
        reset = 1'b1;
        start = 1'b1;
        numSamples = 32'd5;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (sorterClear !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_at_release: got clear=%b busy=%b expected 0 0", sorterClear, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || memRdEn !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_release: got busy=%b done=%b rd=%b expected 0 0 0", busy, done, memRdEn);
        end
    endtask

    task automatic test_zero_samples();
        int rd0, v0;
        rd0 = rd_cnt;
        v0  = got_name_q.size();
        start_query(32'd0, 32'd0);
        checks++;
        if (sorterClear !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_clear: got clear=%b busy=%b done=%b expected 1 1 0", sorterClear, busy, done);
        end
        @(negedge clk);
        checks++;
        if (sorterClear !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got clear=%b done=%b busy=%b expected 0 1 0", sorterClear, done, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rd_cnt != rd0 || got_name_q.size() != v0) begin
            failures++;
            $display("FAIL zero_no_traffic: got reads=%0d pairs=%0d expected 0 0", rd_cnt - rd0, got_name_q.size() - v0);
        end
    endtask

    task automatic test_basic_stream();
        // Cycles 1..8 after the start edge, hand-derived from the 3-cycle latency.
        bit          e_rd   [8] = '{0, 1, 1, 1, 0, 0, 0, 0};
        logic [6:0]  e_addr [8] = '{0, 0, 1, 2, 0, 0, 0, 0};
        bit          e_v    [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        logic [31:0] e_name [8] = '{0, 0, 0, 0, 0, 1, 2, 0};
        logic [31:0] e_val  [8] = '{0, 0, 0, 0, 25, 0, 400, 0};
        bit          e_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        bit          e_clr  [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        load_basic_mem();
        start_query(32'd3, pk(8'd10, 8'd10, 8'd10, 8'd10));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (memRdEn !== e_rd[k] || (e_rd[k] && memAddr !== e_addr[k])) begin
                failures++;
                $display("FAIL basic_read c%0d: got rd=%b addr=%0d expected rd=%b addr=%0d", k + 1, memRdEn, memAddr, e_rd[k], e_addr[k]);
            end
            checks++;
            if (valid !== e_v[k] || (e_v[k] && (dataName !== e_name[k] || dataValue !== e_val[k]))) begin
                failures++;
                $display("FAIL basic_pair c%0d: got v=%b (%0d,%0d) expected v=%b (%0d,%0d)", k + 1, valid, dataName, dataValue, e_v[k], e_name[k], e_val[k]);
            end
            checks++;
            if (done !== e_done[k] || sorterClear !== e_clr[k]) begin
                failures++;
                $display("FAIL basic_ctrl c%0d: got done=%b clear=%b expected done=%b clear=%b", k + 1, done, sorterClear, e_done[k], e_clr[k]);
            end
        end
    endtask

    task automatic test_clamp();
        int base, rd0, ov0;
        bit ok;
        for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
        base = got_name_q.size();
        rd0  = rd_cnt;
        ov0  = overlap;
        start_query(32'd200, 32'd0);
        wait_done(400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL clamp_timeout: got done=0 expected done=1 within 400 cycles");
        end
        checks++;
        if (got_name_q.size() - base != 128 || rd_cnt - rd0 != 128) begin
            failures++;
            $display("FAIL clamp_count: got pairs=%0d reads=%0d expected 128 128", got_name_q.size() - base, rd_cnt - rd0);
        end
        for (int i = 0; i < 128 && base + i < got_name_q.size(); i++) begin
            checks++;
            if (got_name_q[base + i] !== 32'(i) || got_val_q[base + i] !== 32'd260100) begin
                failures++;
                $display("FAIL clamp_pair %0d: got (%0d,%0d) expected (%0d,260100)", i, got_name_q[base + i], got_val_q[base + i], i);
            end
        end
        checks++;
        if (overlap != ov0) begin
            failures++;
            $display("FAIL clamp_done_overlap: got %0d overlapping cycles expected 0", overlap - ov0);
        end
    endtask

    task automatic test_saturation();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        s_numSamples = 32'd1;
        s_query = 32'd0;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL sat_timeout: got no valid expected one valid within 20 cycles");
        end else begin
            checks++;
            if (s_dataValue !== 16'hFFFE || s_dataName !== 32'd0) begin
                failures++;
                $display("FAIL sat_value: got (%0d,%h) expected (0,fffe)", s_dataName, s_dataValue);
            end
        end
    endtask

    task automatic test_start_ignored();
        int base, cb, rd0;
        bit ok;
        logic [31:0] e_val [3] = '{25, 0, 400};
        load_basic_mem();
        base = got_name_q.size();
        cb   = clr_cyc_q.size();
        rd0  = rd_cnt;
        start_query(32'd3, pk(8'd10, 8'd10, 8'd10, 8'd10));
        @(negedge clk);
        start = 1'b1;
        numSamples = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(50, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || clr_cyc_q.size() - cb != 1 || rd_cnt - rd0 != 3 || got_name_q.size() - base != 3) begin
            failures++;
            $display("FAIL ignored_start: got done=%b clears=%0d reads=%0d pairs=%0d expected 1 1 3 3", ok, clr_cyc_q.size() - cb, rd_cnt - rd0, got_name_q.size() - base);
        end
        for (int i = 0; i < 3 && base + i < got_name_q.size(); i++) begin
            checks++;
            if (got_name_q[base + i] !== 32'(i) || got_val_q[base + i] !== e_val[i]) begin
                failures++;
                $display("FAIL ignored_pair %0d: got (%0d,%0d) expected (%0d,%0d)", i, got_name_q[base + i], got_val_q[base + i], i, e_val[i]);
            end
        end
    endtask

    task automatic test_restart();
        int base, cb;
        bit ok;
        base = got_name_q.size();
        cb   = clr_cyc_q.size();
        start_query(32'd2, pk(8'd10, 8'd10, 8'd10, 8'd10));
        checks++;
        if (done !== 1'b0 || sorterClear !== 1'b1) begin
            failures++;
            $display("FAIL restart_ctrl: got done=%b clear=%b expected 0 1", done, sorterClear);
        end
        wait_done(50, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || got_name_q.size() - base != 2 || clr_cyc_q.size() - cb != 1) begin
            failures++;
            $display("FAIL restart_count: got done=%b pairs=%0d clears=%0d expected 1 2 1", ok, got_name_q.size() - base, clr_cyc_q.size() - cb);
        end else begin
            checks++;
            if (got_name_q[base] !== 32'd0 || got_val_q[base] !== 32'd25 ||
                got_name_q[base + 1] !== 32'd1 || got_val_q[base + 1] !== 32'd0) begin
                failures++;
                $display("FAIL restart_pairs: got (%0d,%0d)(%0d,%0d) expected (0,25)(1,0)", got_name_q[base], got_val_q[base], got_name_q[base + 1], got_val_q[base + 1]);
            end
            checks++;
            if (clr_cyc_q[cb] >= got_cyc_q[base]) begin
                failures++;
                $display("FAIL restart_order: got clear at %0d first valid at %0d expected clear first", clr_cyc_q[cb], got_cyc_q[base]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, cb, rd0;
        start_query(32'd100, pk(8'd10, 8'd10, 8'd10, 8'd10));
        repeat (5) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || memRdEn !== 1'b1) begin
            failures++;
            $display("FAIL mid_stream_active: got valid=%b rd=%b expected 1 1", valid, memRdEn);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || memRdEn !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b rd=%b done=%b busy=%b expected 0 0 0 0", valid, memRdEn, done, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base = got_name_q.size();
        cb   = clr_cyc_q.size();
        rd0  = rd_cnt;
        repeat (10) @(negedge clk);
        checks++;
        if (got_name_q.size() != base || clr_cyc_q.size() != cb || rd_cnt != rd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got pairs=%0d clears=%0d reads=%0d busy=%b done=%b expected all 0", got_name_q.size() - base, clr_cyc_q.size() - cb, rd_cnt - rd0, busy, done);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_zero_samples();
        test_basic_stream();
        test_clamp();
        test_saturation();
        test_start_ignored();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
